// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-port byte memory behind a request/response handshake. It serves
//   instruction fetches, two-byte operand fetches (burst read of addr and
//   addr+1) and accumulator stores. The access latency is fixed by LATENCY.
//   Only one transaction is in flight at a time. A request made while busy
//   is dropped, not queued.
//
// Parameters
//   ADDR_WIDTH  byte address width; the memory holds 2**ADDR_WIDTH bytes
//   DATA_WIDTH  word width
//   LATENCY     edges from the accept edge to the first response edge (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (memory contents are kept)
//   i_req      access request, sampled only while o_busy is low
//   i_we       1 = write, 0 = read, sampled with i_req
//   i_burst    1 = two-byte read, ignored for writes
//   i_addr     byte address, sampled with i_req
//   i_wdata    write data, sampled with i_req
//   o_rdata    read data; valid with o_rvalid, holds its value otherwise
//   o_rvalid   one-cycle pulse per returned read byte
//   o_last     high together with the final read beat of a transaction
//   o_done     one-cycle pulse when a transaction completes
//   o_busy     a transaction is in flight
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic                  i_burst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_last,
    output logic                  o_done,
    output logic                  o_busy
);

    localparam int CNT_W = 4;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_count;
    logic                    r_we;
    logic                    r_burst;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rvalid;
    logic                    r_last;
    logic                    r_done;
    logic                    r_busy;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_respEdge;
    logic                    w_memWe;

    // The response edge is the WAIT cycle whose countdown has run out.
    assign w_respEdge = (r_state == WAIT) && (r_count == '0);
    assign w_memWe    = w_respEdge && r_we;

    // Memory array has no reset so its contents survive rst. The write is
    // also gated by rst so an aborted store can never land in the array.
    always_ff @(posedge clk) begin
        if (w_memWe && !rst) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Control FSM with registered outputs. rvalid/last/done default low each
    // cycle so they come out as single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_burst  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_burst <= i_burst & ~i_we;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_count <= CNT_W'(LATENCY - 1);
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else if (r_we) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_burst) begin
                        // First beat; the address wraps naturally at the
                        // top of the array for the second beat.
                        r_rdata  <= r_mem[r_addr];
                        r_rvalid <= 1'b1;
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_state  <= BEAT2;
                    end else begin
                        r_rdata  <= r_mem[r_addr];
                        r_rvalid <= 1'b1;
                        r_last   <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                BEAT2: begin
                    r_rdata  <= r_mem[r_addr];
                    r_rvalid <= 1'b1;
                    r_last   <= 1'b1;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_last   = r_last;
    assign o_done   = r_done;
    assign o_busy   = r_busy;

endmodule
